// File: rtl/dm_access_unit.sv
// M-stage data memory initiator: native accesses in one cycle, misaligned split into bytes.
// Optional DM_MISALIGN_EXC_EN: flag misaligned accesses on Exc instead of splitting.
module dm_access_unit #(
  parameter int ADDR_LSB_W = 14
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic [2:0]            Op,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WData,
  output logic [ADDR_LSB_W-3:0] DmAddr,
  output logic [31:0]           DmDin,
  output logic [3:0]            DmBe,
  output logic                  DmWe,
  input  logic [31:0]           DmDout,
  output logic                  Stall,
  output logic [31:0]           RData,
  output logic                  RValid,
  output logic                  Exc
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;

  function automatic logic [7:0] lane8(
    input logic [31:0] w,
    input logic [1:0]  k
  );
    unique case (k)
      2'd0:    lane8 = w[7:0];
      2'd1:    lane8 = w[15:8];
      2'd2:    lane8 = w[23:16];
      default: lane8 = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] ext(
    input logic [2:0]  op,
    input logic [31:0] r
  );
    unique case (op)
      OP_LB:   ext = {{24{r[7]}}, r[7:0]};
      OP_LBU:  ext = {24'b0, r[7:0]};
      OP_LH:   ext = {{16{r[15]}}, r[15:0]};
      OP_LHU:  ext = {16'b0, r[15:0]};
      default: ext = r;
    endcase
  endfunction

  logic        unused_addr;
  logic [1:0]  off;
  logic        is_st;
  logic        is_w;
  logic        is_h;
  logic        native;
  logic [3:0]  nat_be;
  logic [31:0] nat_din;
  logic [31:0] nat_raw;
  logic [31:0] nat_ld;

  assign unused_addr = ^Addr[31:ADDR_LSB_W];
  assign off   = Addr[1:0];
  assign is_st = Op[2] & (Op[1] | Op[0]);
  assign is_w  = (Op == OP_LW) || (Op == OP_SW);
  assign is_h  = (Op == OP_LH) || (Op == OP_LHU) || (Op == OP_SH);
  assign native = !(is_h && off[0]) && !(is_w && (off != 2'd0));

  always_comb begin
    nat_be  = 4'b0001 << off;
    nat_din = {24'b0, WData[7:0]};
    nat_raw = {24'b0, lane8(DmDout, off)};
    unique case (1'b1)
      is_w: begin
        nat_be  = 4'b1111;
        nat_din = WData;
        nat_raw = DmDout;
      end
      is_h: begin
        nat_be  = off[1] ? 4'b1100 : 4'b0011;
        nat_din = {16'b0, WData[15:0]};
        nat_raw = {16'b0, off[1] ? DmDout[31:16] : DmDout[15:0]};
      end
      default: ;
    endcase
  end

  assign nat_ld = ext(Op, nat_raw);

  logic                  in_seq;
  logic [ADDR_LSB_W-3:0] seq_addr;
  logic [3:0]            seq_be;
  logic [31:0]           seq_din;
  logic                  seq_we;
  logic                  seq_stall;

`ifdef DM_MISALIGN_EXC_EN
  assign in_seq    = 1'b0;
  assign seq_addr  = '0;
  assign seq_be    = '0;
  assign seq_din   = '0;
  assign seq_we    = 1'b0;
  assign seq_stall = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RData  <= '0;
      RValid <= 1'b0;
    end else begin
      RValid <= Req && native && !is_st;
      if (Req && native && !is_st)
        RData <= nat_ld;
    end
  end
`else
  typedef enum logic {IDLE, SEQ} state_t;

  state_t                state;
  logic [2:0]            lop;
  logic [ADDR_LSB_W-1:0] laddr;
  logic [31:0]           lwd;
  logic [1:0]            cnt;
  logic [23:0]           acc;
  logic                  lword;
  logic                  lstore;
  logic                  last;
  logic [ADDR_LSB_W-1:0] ba;
  logic [7:0]            dbyte;
  logic [31:0]           seq_ld;

  assign lword  = (lop == OP_LW) || (lop == OP_SW);
  assign lstore = lop[2] & (lop[1] | lop[0]);
  assign last   = cnt == (lword ? 2'd3 : 2'd1);
  // 14-bit add so the byte walk wraps inside the address space
  assign ba     = laddr + ADDR_LSB_W'(cnt);
  assign dbyte  = lane8(DmDout, ba[1:0]);
  assign seq_ld = ext(lop, lword ? {dbyte, acc}
                                 : {16'b0, dbyte, acc[7:0]});

  assign in_seq    = state == SEQ;
  assign seq_addr  = ba[ADDR_LSB_W-1:2];
  assign seq_be    = 4'b0001 << ba[1:0];
  assign seq_din   = lstore ? {24'b0, lane8(lwd, cnt)} : 32'b0;
  assign seq_we    = lstore;
  assign seq_stall = !last;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lop    <= '0;
      laddr  <= '0;
      lwd    <= '0;
      acc    <= '0;
      RData  <= '0;
      RValid <= 1'b0;
    end else begin
      RValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Req && native && !is_st) begin
            RData  <= nat_ld;
            RValid <= 1'b1;
          end else if (Req && !native) begin
            lop   <= Op;
            laddr <= Addr[ADDR_LSB_W-1:0];
            lwd   <= WData;
            cnt   <= '0;
            state <= SEQ;
          end
        end
        SEQ: begin
          unique case (cnt)
            2'd0:    acc[7:0]   <= dbyte;
            2'd1:    acc[15:8]  <= dbyte;
            2'd2:    acc[23:16] <= dbyte;
            default: ;
          endcase
          cnt <= cnt + 2'd1;
          if (last) begin
            state <= IDLE;
            if (!lstore) begin
              RData  <= seq_ld;
              RValid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  always_comb begin
    DmAddr = Addr[ADDR_LSB_W-1:2];
    DmBe   = 4'b0000;
    DmDin  = 32'b0;
    DmWe   = 1'b0;
    Stall  = 1'b0;
    Exc    = 1'b0;
    if (in_seq) begin
      DmAddr = seq_addr;
      DmBe   = seq_be;
      DmDin  = seq_din;
      DmWe   = seq_we;
      Stall  = seq_stall;
    end else if (Req && native) begin
      DmBe  = nat_be;
      DmDin = is_st ? nat_din : 32'b0;
      DmWe  = is_st;
    end else if (Req) begin
`ifdef DM_MISALIGN_EXC_EN
      Exc = 1'b1;
`else
      Stall = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a byte-lane memory model.
// Misaligned split steps run by default; Exc steps with DM_MISALIGN_EXC_EN.
module tb_dm_access_unit;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LHU = 3'd2;
  localparam logic [2:0] LB  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] SW  = 3'd5;
  localparam logic [2:0] SB  = 3'd7;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [11:0] DmAddr;
  logic [31:0] DmDin;
  logic [3:0]  DmBe;
  logic        DmWe;
  logic [31:0] DmDout;
  logic        Stall;
  logic [31:0] RData;
  logic        RValid;
  logic        Exc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  dm_access_unit dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op),
    .Addr(Addr), .WData(WData), .DmAddr(DmAddr),
    .DmDin(DmDin), .DmBe(DmBe), .DmWe(DmWe),
    .DmDout(DmDout), .Stall(Stall), .RData(RData),
    .RValid(RValid), .Exc(Exc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign DmDout = mem[DmAddr];

  always @(posedge Clk) begin
    if (DmWe) begin
      case (DmBe)
        4'b0001: mem[DmAddr][7:0]   <= DmDin[7:0];
        4'b0010: mem[DmAddr][15:8]  <= DmDin[7:0];
        4'b0100: mem[DmAddr][23:16] <= DmDin[7:0];
        4'b1000: mem[DmAddr][31:24] <= DmDin[7:0];
        4'b0011: mem[DmAddr][15:0]  <= DmDin[15:0];
        4'b1100: mem[DmAddr][31:16] <= DmDin[15:0];
        4'b1111: mem[DmAddr]        <= DmDin;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    Req = 1'b1;
    Op = op;
    Addr = a;
    WData = wd;
    #1;
  endtask

  task automatic idle();
    Req = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    Req = 1'b0;
    Op = LW;
    Addr = '0;
    WData = '0;
    step();
    step();
    chk("rst_rdata", RData, 32'h0);
    chk("rst_rvalid", {31'b0, RValid}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_we", {31'b0, DmWe}, 32'h0);
    chk("rst_be", {28'b0, DmBe}, 32'h0);
    chk("rst_exc", {31'b0, Exc}, 32'h0);
    Reset = 1'b0;

    drive(SW, 32'h0010, 32'h12345678);
    chk("sw_be", {28'b0, DmBe}, 32'hF);
    chk("sw_we", {31'b0, DmWe}, 32'h1);
    chk("sw_addr", {20'b0, DmAddr}, 32'h4);
    chk("sw_din", DmDin, 32'h12345678);
    chk("sw_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("sw_rvalid", {31'b0, RValid}, 32'h0);
    drive(LW, 32'h0010, 32'h0);
    chk("lw_be", {28'b0, DmBe}, 32'hF);
    chk("lw_we", {31'b0, DmWe}, 32'h0);
    chk("lw_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("lw_rdata", RData, 32'h12345678);
    chk("lw_rvalid", {31'b0, RValid}, 32'h1);

    drive(SB, 32'h0013, 32'hFFFFFFAB);
    chk("sb_be", {28'b0, DmBe}, 32'h8);
    chk("sb_din", DmDin, 32'h000000AB);
    step();
    drive(LW, 32'h0010, 32'h0);
    step();
    chk("sb_lw_rdata", RData, 32'hAB345678);

    idle();
    chk("idle_we", {31'b0, DmWe}, 32'h0);
    chk("idle_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("idle_rvalid", {31'b0, RValid}, 32'h0);
    chk("idle_hold", RData, 32'hAB345678);

    drive(SW, 32'h0010, 32'h80FF0000);
    step();
    drive(LH, 32'h0012, 32'h0);
    chk("lh_be", {28'b0, DmBe}, 32'hC);
    step();
    chk("lh_rdata", RData, 32'hFFFF80FF);
    drive(LHU, 32'h0012, 32'h0);
    step();
    chk("lhu_rdata", RData, 32'h000080FF);

`ifdef DM_MISALIGN_EXC_EN
    drive(LW, 32'h0002, 32'h0);
    chk("exc_flag", {31'b0, Exc}, 32'h1);
    chk("exc_we", {31'b0, DmWe}, 32'h0);
    chk("exc_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("exc_rvalid", {31'b0, RValid}, 32'h0);
    drive(SW, 32'h0011, 32'hDEADBEEF);
    chk("exc_sw_flag", {31'b0, Exc}, 32'h1);
    chk("exc_sw_we", {31'b0, DmWe}, 32'h0);
    step();
    drive(LW, 32'h0010, 32'h0);
    chk("exc_lw_exc", {31'b0, Exc}, 32'h0);
    step();
    chk("exc_mem_kept", RData, 32'h80FF0000);
`else
    drive(SW, 32'h0020, 32'h0);
    step();
    drive(SW, 32'h0024, 32'h0);
    step();
    drive(SW, 32'h0021, 32'hDDCCBBAA);
    chk("mis_acc_stall", {31'b0, Stall}, 32'h1);
    chk("mis_acc_we", {31'b0, DmWe}, 32'h0);
    step();
    chk("mis_b0_addr", {20'b0, DmAddr}, 32'h8);
    chk("mis_b0_be", {28'b0, DmBe}, 32'h2);
    chk("mis_b0_din", DmDin, 32'hAA);
    chk("mis_b0_we", {31'b0, DmWe}, 32'h1);
    chk("mis_b0_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("mis_b1_be", {28'b0, DmBe}, 32'h4);
    chk("mis_b1_din", DmDin, 32'hBB);
    chk("mis_b1_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("mis_b2_be", {28'b0, DmBe}, 32'h8);
    chk("mis_b2_din", DmDin, 32'hCC);
    chk("mis_b2_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("mis_b3_addr", {20'b0, DmAddr}, 32'h9);
    chk("mis_b3_be", {28'b0, DmBe}, 32'h1);
    chk("mis_b3_din", DmDin, 32'hDD);
    chk("mis_b3_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("mis_st_rvalid", {31'b0, RValid}, 32'h0);
    chk("mis_mem8", mem[8], 32'hCCBBAA00);
    chk("mis_mem9", mem[9], 32'h000000DD);

    drive(LW, 32'h0021, 32'h0);
    chk("mlw_acc_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("mlw_b0_we", {31'b0, DmWe}, 32'h0);
    chk("mlw_b0_stall", {31'b0, Stall}, 32'h1);
    chk("mlw_b0_rvalid", {31'b0, RValid}, 32'h0);
    step();
    step();
    chk("mlw_b2_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("mlw_b3_stall", {31'b0, Stall}, 32'h0);
    chk("mlw_b3_rvalid", {31'b0, RValid}, 32'h0);
    step();
    chk("mlw_rdata", RData, 32'hDDCCBBAA);
    chk("mlw_rvalid", {31'b0, RValid}, 32'h1);

    drive(SB, 32'h3FFF, 32'h34);
    chk("sb_top_addr", {20'b0, DmAddr}, 32'hFFF);
    step();
    drive(SB, 32'h0000, 32'h92);
    step();
    drive(LH, 32'h3FFF, 32'h0);
    chk("wrap_acc_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("wrap_b0_addr", {20'b0, DmAddr}, 32'hFFF);
    chk("wrap_b0_be", {28'b0, DmBe}, 32'h8);
    chk("wrap_b0_stall", {31'b0, Stall}, 32'h1);
    step();
    chk("wrap_b1_addr", {20'b0, DmAddr}, 32'h0);
    chk("wrap_b1_be", {28'b0, DmBe}, 32'h1);
    chk("wrap_b1_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("wrap_rdata", RData, 32'hFFFF9234);
    chk("wrap_rvalid", {31'b0, RValid}, 32'h1);
    drive(LB, 32'h0000, 32'h0);
    step();
    chk("lb_neg", RData, 32'hFFFFFF92);
    drive(LBU, 32'h0000, 32'h0);
    step();
    chk("lbu", RData, 32'h00000092);
    drive(LB, 32'h3FFF, 32'h0);
    step();
    chk("lb_pos", RData, 32'h00000034);

    drive(SW, 32'h0040, 32'h0);
    step();
    drive(SW, 32'h0044, 32'h0);
    step();
    drive(SW, 32'h0041, 32'h44332211);
    step();
    step();
    chk("rs_b1_be", {28'b0, DmBe}, 32'h4);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle();
    chk("rs_stall", {31'b0, Stall}, 32'h0);
    chk("rs_we", {31'b0, DmWe}, 32'h0);
    chk("rs_rvalid", {31'b0, RValid}, 32'h0);
    step();
    chk("rs_mem10", mem[16], 32'h00221100);
    chk("rs_mem11", mem[17], 32'h00000000);
    drive(LW, 32'h0040, 32'h0);
    chk("rs_lw_stall", {31'b0, Stall}, 32'h0);
    step();
    chk("rs_lw_rdata", RData, 32'h00221100);
`endif

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
